// File: rtl/and_pkg.sv
// Shared types and helpers for the bit-serial AND transmitter.
// Holds the serializer FSM state type and the bit-counter width helper.
package and_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // A counter that must reach width-1; a one-bit floor keeps tiny widths legal.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/and_gate.sv
// Parallel bitwise AND stage shared by the AND datapath.
// Purely combinational: y = a & b.
module and_gate #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   assign y = a & b;

endmodule

// File: rtl/and_serializer.sv
// Bit-serial transmitter: latches a & b on accept and shifts the product out
// LSB-first with a last-bit marker, supporting back-to-back frames.
module and_serializer
   import and_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ser_data,
   output logic             ser_valid,
   output logic             ser_last,
   input  logic             ser_ready,
   output logic             busy
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] PRELAST_CNT = CW'(WIDTH - 2);

   state_t           state;
   logic [WIDTH-1:0] product;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    bitcnt;
   logic             beat;
   logic             load;

   and_gate #(.WIDTH(WIDTH)) u_and_gate (
      .a (a),
      .b (b),
      .y (product)
   );

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // in_valid/in_ready move an operand pair; ser_valid/ser_ready move one bit.
   // in_ready also opens on the final beat so the next frame follows with no gap.
   assign beat     = ser_valid && ser_ready;
   assign in_ready = rst_n && (state == IDLE || (beat && ser_last));
   assign load     = in_valid && in_ready;
   assign ser_data = shreg[0];
   assign busy     = ser_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         bitcnt    <= '0;
         ser_valid <= 1'b0;
         ser_last  <= 1'b0;
      end else if (load) begin
         state     <= SHIFT;
         shreg     <= product;
         bitcnt    <= '0;
         ser_valid <= 1'b1;
         ser_last  <= 1'b0;
      end else if (beat) begin
         shreg <= shreg >> 1;
         if (ser_last) begin
            state     <= IDLE;
            bitcnt    <= '0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
         end else begin
            bitcnt   <= bitcnt + CW'(1);
            ser_last <= (bitcnt == PRELAST_CNT);
         end
      end
   end

endmodule

// File: tb/tb_and_serializer.sv
// Self-checking bench for and_serializer: directed scenarios plus a randomized
// run, compared against a frame-position model and a bit scoreboard.
module tb_and_serializer;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ser_data;
   logic             ser_valid;
   logic             ser_last;
   logic             ser_ready;
   logic             busy;

   int checks = 0;
   int errors = 0;

   // Model: m_pos is the index of the bit on the wire, -1 when no frame.
   int               m_pos = -1;
   logic [WIDTH-1:0] m_word = '0;
   logic [0:0]       exp_q[$];

   always #5 clk = ~clk;

   and_serializer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ser_data  (ser_data),
      .ser_valid (ser_valid),
      .ser_last  (ser_last),
      .ser_ready (ser_ready),
      .busy      (busy)
   );

   function automatic logic m_valid();
      return m_pos >= 0;
   endfunction

   function automatic logic m_last();
      return m_pos == WIDTH - 1;
   endfunction

   function automatic logic m_data();
      return (m_pos >= 0) ? m_word[m_pos] : 1'b0;
   endfunction

   function automatic logic m_ready();
      return rst_n && (m_pos < 0 || (ser_ready && m_pos == WIDTH - 1));
   endfunction

   // {valid, last, ready, busy, data-when-valid}
   function automatic logic [4:0] exp_vec();
      return {m_valid(), m_last(), m_ready(), m_valid(), m_data()};
   endfunction

   function automatic logic [4:0] got_vec();
      return {ser_valid, ser_last, in_ready, busy, m_valid() ? ser_data : 1'b0};
   endfunction

   task automatic drive(input logic rn, input logic iv, input logic [WIDTH-1:0] ia,
                        input logic [WIDTH-1:0] ib, input logic sr);
      rst_n     = rn;
      in_valid  = iv;
      a         = ia;
      b         = ib;
      ser_ready = sr;
      #1;
   endtask

   task automatic advance();
      if (!rst_n) begin
         m_pos  = -1;
         m_word = '0;
      end else if (in_valid && m_ready()) begin
         m_word = a & b;
         m_pos  = 0;
      end else if (m_pos >= 0 && ser_ready) begin
         m_pos++;
         if (m_pos == WIDTH) m_pos = -1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
         checks++;
         if ({in_ready, ser_valid, ser_data, ser_last, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset cyc %0d got rdy/v/d/l/b=%b want 00000", i,
                     {in_ready, ser_valid, ser_data, ser_last, busy});
         end
         advance();
      end
      drive(1'b1, 1'b0, '0, '0, 1'b1);
      checks++;
      if (in_ready !== 1'b1 || ser_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got rdy=%b v=%b want rdy=1 v=0", in_ready, ser_valid);
      end
      advance();
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] exp_bits;
      exp_bits = 8'h30;
      drive(1'b1, 1'b1, 8'hF0, 8'h3C, 1'b1);
      checks++;
      if (got_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL basic_accept got %b want %b", got_vec(), exp_vec());
      end
      advance();
      for (int i = 0; i < WIDTH; i++) begin
         drive(1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'b1);
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL basic_model bit %0d got %b want %b", i, got_vec(), exp_vec());
         end
         checks++;
         if (ser_valid !== 1'b1 || ser_data !== exp_bits[i] || ser_last !== (i == WIDTH - 1)) begin
            errors++;
            $display("FAIL basic_bit %0d got v/d/l=%b%b%b want 1%b%b", i, ser_valid, ser_data,
                     ser_last, exp_bits[i], (i == WIDTH - 1));
         end
         advance();
      end
      drive(1'b1, 1'b0, '0, '0, 1'b1);
      checks++;
      if (ser_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_idle got v=%b rdy=%b want v=0 rdy=1", ser_valid, in_ready);
      end
      advance();
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] rx;
      int               vcnt;
      int               nbit;
      logic             sr;
      rx   = '0;
      vcnt = 0;
      nbit = 0;
      drive(1'b1, 1'b1, 8'hA5 | 8'($urandom), 8'hA5, 1'b1);
      advance();
      for (int cyc = 0; cyc < 11; cyc++) begin
         sr = !(cyc >= 2 && cyc <= 4);
         drive(1'b1, 1'b0, 8'($urandom), 8'($urandom), sr);
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL bp_model cyc %0d got %b want %b", cyc, got_vec(), exp_vec());
         end
         if (cyc >= 2 && cyc <= 5) begin
            checks++;
            if (ser_data !== 1'b1 || ser_valid !== 1'b1) begin
               errors++;
               $display("FAIL bp_hold cyc %0d got d=%b v=%b want d=1 v=1", cyc, ser_data, ser_valid);
            end
         end
         if (ser_valid === 1'b1) vcnt++;
         if (ser_valid === 1'b1 && sr && nbit < WIDTH) begin
            rx[nbit] = ser_data;
            nbit++;
         end
         advance();
      end
      drive(1'b1, 1'b0, '0, '0, 1'b1);
      checks++;
      if (vcnt != 11 || rx !== 8'hA5 || ser_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_frame got span=%0d bits=%h v_after=%b want span=11 bits=a5 v_after=0",
                  vcnt, rx, ser_valid);
      end
      advance();
   endtask

   task automatic test_back_to_back();
      logic [2*WIDTH-1:0] rx;
      int                 vcnt;
      rx   = '0;
      vcnt = 0;
      drive(1'b1, 1'b1, 8'hFF, 8'hAA, 1'b1);
      advance();
      for (int cyc = 0; cyc < 2 * WIDTH; cyc++) begin
         drive(1'b1, cyc < WIDTH, 8'h0F, 8'h0F, 1'b1);
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL b2b_model cyc %0d got %b want %b", cyc, got_vec(), exp_vec());
         end
         if (cyc < WIDTH) begin
            checks++;
            if (in_ready !== (cyc == WIDTH - 1)) begin
               errors++;
               $display("FAIL b2b_ready cyc %0d got %b want %b", cyc, in_ready, (cyc == WIDTH - 1));
            end
         end
         if (ser_valid === 1'b1) vcnt++;
         rx[cyc] = ser_data;
         advance();
      end
      drive(1'b1, 1'b0, '0, '0, 1'b1);
      checks++;
      if (vcnt != 2 * WIDTH || rx !== 16'h0FAA || ser_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stream got valid_cycles=%0d bits=%h v_after=%b want 16 0faa 0",
                  vcnt, rx, ser_valid);
      end
      advance();
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
      advance();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, '0, '0, 1'b1);
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL rmid_pre bit %0d got %b want %b", i, got_vec(), exp_vec());
         end
         advance();
      end
      drive(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
      checks++;
      if (ser_valid !== 1'b1 || ser_data !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rmid_assert got v/d/rdy=%b%b%b want 110", ser_valid, ser_data, in_ready);
      end
      advance();
      drive(1'b1, 1'b0, '0, '0, 1'b1);
      checks++;
      if (ser_valid !== 1'b0 || got_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL rmid_abort got v=%b vec=%b want v=0 vec=%b", ser_valid, got_vec(), exp_vec());
      end
      advance();
      drive(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
      advance();
      for (int i = 0; i < WIDTH; i++) begin
         drive(1'b1, 1'b0, '0, '0, 1'b1);
         checks++;
         if (got_vec() !== exp_vec() || ser_last !== (i == WIDTH - 1)) begin
            errors++;
            $display("FAIL rmid_next bit %0d got %b last=%b want %b", i, got_vec(), ser_last, exp_vec());
         end
         advance();
      end
   endtask

   task automatic test_zero_change();
      drive(1'b1, 1'b1, 8'h55, 8'hAA, 1'b1);
      advance();
      for (int i = 0; i < WIDTH; i++) begin
         drive(1'b1, 1'b0, 8'hFF, 8'hAA, 1'b1);
         checks++;
         if (ser_valid !== 1'b1 || ser_data !== 1'b0 || ser_last !== (i == WIDTH - 1)) begin
            errors++;
            $display("FAIL zero bit %0d got v/d/l=%b%b%b want 10%b", i, ser_valid, ser_data,
                     ser_last, (i == WIDTH - 1));
         end
         advance();
      end
      drive(1'b1, 1'b0, '0, '0, 1'b1);
      checks++;
      if (ser_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_idle got v=%b rdy=%b want v=0 rdy=1", ser_valid, in_ready);
      end
      advance();
   endtask

   task automatic test_random();
      logic             rn;
      logic             iv;
      logic             sr;
      logic [WIDTH-1:0] prod;
      logic [0:0]       bit_exp;
      exp_q.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         rn = ($urandom_range(0, 63) != 0);
         iv = 1'($urandom_range(0, 1));
         sr = ($urandom_range(0, 3) != 0);
         drive(rn, iv, 8'($urandom), 8'($urandom), sr);
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL rand_model cyc %0d got %b want %b", cyc, got_vec(), exp_vec());
         end
         if (!rst_n) begin
            exp_q.delete();
         end else begin
            if (m_valid() && ser_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL rand_sb cyc %0d unexpected beat d=%b", cyc, ser_data);
               end else begin
                  bit_exp = exp_q.pop_front();
                  if (ser_data !== bit_exp[0] || ser_last !== (exp_q.size() == 0)) begin
                     errors++;
                     $display("FAIL rand_sb cyc %0d got d=%b l=%b want d=%b l=%b", cyc, ser_data,
                              ser_last, bit_exp[0], (exp_q.size() == 0));
                  end
               end
            end
            if (in_valid && m_ready()) begin
               prod = a & b;
               for (int k = 0; k < WIDTH; k++) exp_q.push_back(prod[k]);
            end
         end
         advance();
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      ser_ready = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_zero_change();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
